// File: rtl/axis_cplx_round_clip_pkg.sv
// Shared arithmetic for the complex round/clip block: drop-width calculation,
// saturation bounds and the per-component round-then-saturate function.
package axis_cplx_pkg;

    // Wide enough to hold any supported input component plus the rounding carry.
    localparam int CALC_W = 64;

    function automatic int drop_bits(input int width_in, input int width_out, input int clip_bits);
        return width_in - width_out - clip_bits;
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_max(input int width_out);
        logic signed [CALC_W-1:0] one;
        one = 64'sd1;
        return (one <<< (width_out - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_min(input int width_out);
        logic signed [CALC_W-1:0] one;
        one = 64'sd1;
        return -(one <<< (width_out - 1));
    endfunction

    // Adding half an LSB before the arithmetic shift makes ties round toward +infinity.
    function automatic logic signed [CALC_W-1:0] round_sat(input logic signed [CALC_W-1:0] x,
                                                           input int drop,
                                                           input int width_out);
        logic signed [CALC_W-1:0] one;
        logic signed [CALC_W-1:0] r;
        one = 64'sd1;
        r   = (x + (one <<< (drop - 1))) >>> drop;
        if (r > sat_max(width_out)) begin
            r = sat_max(width_out);
        end else if (r < sat_min(width_out)) begin
            r = sat_min(width_out);
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_cplx_round_clip_if.sv
// AXI-Stream beat bundle (data, last, valid/ready) used on both sides of the
// round/clip block and between its pipeline stage and output FIFO.
interface axis_cplx_round_clip_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] tdata;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_cplx_round_clip_fifo.sv
// Power-of-two ring buffer for AXI-Stream beats ({last,data}); ready comes from
// a registered full state so a read never lets a same-cycle write into a full FIFO.
module axis_ring_fifo #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    axis_cplx_round_clip_if.slave  w,
    axis_cplx_round_clip_if.master r
);
    localparam int DEPTH = 1 << SIZE;

    logic [WIDTH:0]  mem [DEPTH];
    logic [SIZE-1:0] wr_ptr;
    logic [SIZE-1:0] rd_ptr;
    logic [SIZE:0]   count;
    logic            full;
    logic            not_empty;
    logic            wr_en;
    logic            rd_en;

    assign full      = (count == (SIZE + 1)'(DEPTH));
    assign not_empty = (count != '0);
    assign wr_en     = w.tvalid & ~full;
    assign rd_en     = not_empty & r.tready;

    assign w.tready = ~full;
    assign r.tvalid = not_empty;
    // Drive zeros while empty so the output reads as all-zero after reset/clear.
    assign {r.tlast, r.tdata} = not_empty ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem[wr_ptr] <= {w.tlast, w.tdata};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axis_cplx_round_clip.sv
// Converts wide {I,Q} samples to narrow ones (round, then saturate) through one
// handshaked register stage, optionally followed by an output FIFO.
module axis_cplx_round_clip
    import axis_cplx_pkg::*;
#(
    parameter int WIDTH_IN  = 32,
    parameter int WIDTH_OUT = 16,
    parameter int CLIP_BITS = 1,
    parameter int FIFOSIZE  = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    axis_cplx_round_clip_if.slave  i,
    axis_cplx_round_clip_if.master o
);
    localparam int DROP = drop_bits(WIDTH_IN, WIDTH_OUT, CLIP_BITS);

    logic signed [CALC_W-1:0] i_wide;
    logic signed [CALC_W-1:0] q_wide;
    logic [WIDTH_OUT-1:0]     i_rnd;
    logic [WIDTH_OUT-1:0]     q_rnd;
    logic                     stage_valid;
    logic                     stage_last;
    logic [2*WIDTH_OUT-1:0]   stage_data;
    logic                     load;

    axis_cplx_round_clip_if #(.WIDTH(2*WIDTH_OUT)) stg ();

    assign i_wide = CALC_W'($signed(i.tdata[2*WIDTH_IN-1:WIDTH_IN]));
    assign q_wide = CALC_W'($signed(i.tdata[WIDTH_IN-1:0]));
    assign i_rnd  = WIDTH_OUT'(round_sat(i_wide, DROP, WIDTH_OUT));
    assign q_rnd  = WIDTH_OUT'(round_sat(q_wide, DROP, WIDTH_OUT));

    assign load     = i.tvalid & (~stage_valid | stg.tready);
    assign i.tready = ~stage_valid | stg.tready;

    // Clear is checked before the load so a same-cycle handshake is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_valid <= 1'b0;
            stage_last  <= 1'b0;
            stage_data  <= '0;
        end else if (clear) begin
            stage_valid <= 1'b0;
            stage_last  <= 1'b0;
            stage_data  <= '0;
        end else if (load) begin
            stage_valid <= 1'b1;
            stage_last  <= i.tlast;
            stage_data  <= {i_rnd, q_rnd};
        end else if (stg.tready) begin
            stage_valid <= 1'b0;
        end
    end

    assign stg.tvalid = stage_valid;
    assign stg.tlast  = stage_last;
    assign stg.tdata  = stage_data;

    generate
        if (FIFOSIZE > 0) begin : g_fifo
            axis_ring_fifo #(
                .WIDTH (2*WIDTH_OUT),
                .SIZE  (FIFOSIZE)
            ) u_fifo (
                .clk     (clk),
                .reset_n (reset_n),
                .clear   (clear),
                .w       (stg),
                .r       (o)
            );
        end else begin : g_direct
            assign o.tdata    = stg.tdata;
            assign o.tlast    = stg.tlast;
            assign o.tvalid   = stg.tvalid;
            assign stg.tready = o.tready;
        end
    endgenerate

endmodule

// File: tb/tb_axis_cplx_round_clip.sv
// Self-checking bench: a no-FIFO and an 8-deep-FIFO instance, each scored against
// an arithmetic reference model, plus directed rounding/backpressure/reset/clear cases.
module tb_axis_cplx_round_clip;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    axis_cplx_round_clip_if #(.WIDTH(64)) in0 ();
    axis_cplx_round_clip_if #(.WIDTH(64)) in3 ();
    axis_cplx_round_clip_if #(.WIDTH(32)) out0 ();
    axis_cplx_round_clip_if #(.WIDTH(32)) out3 ();

    axis_cplx_round_clip #(.WIDTH_IN(32), .WIDTH_OUT(16), .CLIP_BITS(1), .FIFOSIZE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .i(in0), .o(out0));
    axis_cplx_round_clip #(.WIDTH_IN(32), .WIDTH_OUT(16), .CLIP_BITS(1), .FIFOSIZE(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .i(in3), .o(out3));

    int cmpCount = 0;
    int errCount = 0;
    int outCnt3 = 0;
    logic [32:0] q0[$];
    logic [32:0] q3[$];
    logic hold0 = 1'b0;
    logic hold3 = 1'b0;
    logic [33:0] prev0;
    logic [33:0] prev3;
    localparam logic [63:0] NONE = 64'hFFFF_FFFF_FFFF_FFFF;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        cmpCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: floor((x + 2^14) / 2^15), then clamp to the 16-bit signed range.
    function automatic logic [15:0] rc(input logic [31:0] x);
        longint v;
        longint r;
        v = longint'($signed(x)) + 64'sd16384;
        if (v >= 0) r = v / 32768;
        else        r = -((-v + 32767) / 32768);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    function automatic logic [32:0] model(input logic [63:0] d, input logic l);
        return {l, rc(d[63:32]), rc(d[31:0])};
    endfunction

    function automatic logic [31:0] randComp();
        int v;
        case ($urandom_range(0, 3))
            0:       v = int'($urandom);
            1:       v = int'($urandom_range(0, 131071)) - 65536;
            2:       v = 32'h3FFF0000 + int'($urandom_range(0, 131071));
            default: v = 32'hBFFF0000 + int'($urandom_range(0, 131071));
        endcase
        return v;
    endfunction

    function automatic logic [63:0] randData();
        return {randComp(), randComp()};
    endfunction

    // Scoreboards and output-stability monitors, sampled on the falling edge.
    always @(negedge reset_n) begin
        q0.delete();
        q3.delete();
        hold0 = 1'b0;
        hold3 = 1'b0;
    end

    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset_n || clear) begin
            q0.delete();
            q3.delete();
            hold0 = 1'b0;
            hold3 = 1'b0;
        end else begin
            if (hold0) checkOutput("stable0", {out0.tvalid, out0.tlast, out0.tdata}, prev0);
            if (hold3) checkOutput("stable3", {out3.tvalid, out3.tlast, out3.tdata}, prev3);
            if (out0.tvalid && out0.tready) begin
                if (q0.size() > 0) e = {31'd0, q0.pop_front()};
                else               e = NONE;
                checkOutput("sb0", {31'd0, out0.tlast, out0.tdata}, e);
            end
            if (out3.tvalid && out3.tready) begin
                outCnt3++;
                if (q3.size() > 0) e = {31'd0, q3.pop_front()};
                else               e = NONE;
                checkOutput("sb3", {31'd0, out3.tlast, out3.tdata}, e);
            end
            if (in0.tvalid && in0.tready) q0.push_back(model(in0.tdata, in0.tlast));
            if (in3.tvalid && in3.tready) q3.push_back(model(in3.tdata, in3.tlast));
            hold0 = out0.tvalid && !out0.tready;
            hold3 = out3.tvalid && !out3.tready;
            prev0 = {out0.tvalid, out0.tlast, out0.tdata};
            prev3 = {out3.tvalid, out3.tlast, out3.tdata};
        end
    end

    // Presents one beat (called just after a rising edge) and holds it until accepted.
    task automatic applyStimulus(input int sel, input logic [63:0] d, input logic l);
        int n;
        logic acc;
        if (sel == 0) begin in0.tvalid = 1'b1; in0.tdata = d; in0.tlast = l; end
        else          begin in3.tvalid = 1'b1; in3.tdata = d; in3.tlast = l; end
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = (sel == 0) ? in0.tready : in3.tready;
            n++;
            if (!acc) begin @(posedge clk); #1; end
        end
        if (!acc) checkOutput("hs_timeout", {63'd0, acc}, 64'd1);
        @(posedge clk); #1;
        in0.tvalid = 1'b0;
        in3.tvalid = 1'b0;
    endtask

    task automatic randomPhase(input int cycles);
        logic h0;
        logic h3;
        h0 = 1'b1;
        h3 = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            if (!in0.tvalid || h0) begin
                in0.tvalid = ($urandom_range(0, 3) != 0);
                in0.tdata  = randData();
                in0.tlast  = ($urandom_range(0, 7) == 0);
            end
            if (!in3.tvalid || h3) begin
                in3.tvalid = ($urandom_range(0, 3) != 0);
                in3.tdata  = randData();
                in3.tlast  = ($urandom_range(0, 7) == 0);
            end
            out0.tready = ($urandom_range(0, 3) != 0);
            out3.tready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            h0 = in0.tvalid && in0.tready;
            h3 = in3.tvalid && in3.tready;
            @(posedge clk); #1;
        end
        in0.tvalid = 1'b0;
        in3.tvalid = 1'b0;
        out0.tready = 1'b1;
        out3.tready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("drain0", q0.size(), 0);
        checkOutput("drain3", q3.size(), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] dirIn  [11];
        logic [31:0] dirExp [11];
        logic [63:0] sd [8];
        logic [63:0] bd [12];
        logic [63:0] nd;
        int idx;
        int base;
        int n;

        dirIn[0]  = {32'h00004000, 32'h0};        dirExp[0]  = {16'h0001, 16'h0000};
        dirIn[1]  = {32'h00003FFF, 32'h0};        dirExp[1]  = {16'h0000, 16'h0000};
        dirIn[2]  = {32'hFFFFC000, 32'h0};        dirExp[2]  = {16'h0000, 16'h0000};
        dirIn[3]  = {32'h0, 32'hFFFFBFFF};        dirExp[3]  = {16'h0000, 16'hFFFF};
        dirIn[4]  = {32'h3FFF8000, 32'h0};        dirExp[4]  = {16'h7FFF, 16'h0000};
        dirIn[5]  = {32'h40000000, 32'h0};        dirExp[5]  = {16'h7FFF, 16'h0000};
        dirIn[6]  = {32'hC0000000, 32'h0};        dirExp[6]  = {16'h8000, 16'h0000};
        dirIn[7]  = {32'hBFFF0000, 32'h0};        dirExp[7]  = {16'h8000, 16'h0000};
        dirIn[8]  = {32'h3FFFC000, 32'h0};        dirExp[8]  = {16'h7FFF, 16'h0000};
        dirIn[9]  = {32'h0, 32'h40000000};        dirExp[9]  = {16'h0000, 16'h7FFF};
        dirIn[10] = {32'hC0000000, 32'h00004000}; dirExp[10] = {16'h8000, 16'h0001};

        in0.tvalid = 1'b0; in0.tdata = '0; in0.tlast = 1'b0;
        in3.tvalid = 1'b0; in3.tdata = '0; in3.tlast = 1'b0;
        out0.tready = 1'b1;
        out3.tready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out0", {out0.tvalid, out0.tlast, out0.tdata}, 64'd0);
        checkOutput("reset_out3", {out3.tvalid, out3.tlast, out3.tdata}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_ready", {in0.tready, in3.tready}, 64'd3);
        @(posedge clk); #1;

        $display("[TB] rounding and saturation vectors");
        for (int k = 0; k < 11; k++) begin
            applyStimulus(0, dirIn[k], 1'b0);
            @(negedge clk);
            checkOutput("round_sat", {out0.tvalid, out0.tdata}, {31'd0, 1'b1, dirExp[k]});
            @(posedge clk); #1;
        end

        $display("[TB] 8-beat packet streaming");
        for (int k = 0; k < 8; k++) sd[k] = randData();
        for (int k = 0; k < 8; k++) begin
            in0.tvalid = 1'b1;
            in0.tdata  = sd[k];
            in0.tlast  = (k == 7);
            @(negedge clk);
            checkOutput("stream_ready", {63'd0, in0.tready}, 64'd1);
            if (k > 0) checkOutput("stream_out", {out0.tvalid, out0.tlast, out0.tdata},
                                   {30'd0, 1'b1, model(sd[k-1], 1'b0)});
            @(posedge clk); #1;
        end
        in0.tvalid = 1'b0;
        @(negedge clk);
        checkOutput("stream_last", {out0.tvalid, out0.tlast, out0.tdata}, {30'd0, 1'b1, model(sd[7], 1'b1)});
        @(negedge clk);
        checkOutput("stream_idle", {63'd0, out0.tvalid}, 64'd0);
        @(posedge clk); #1;

        $display("[TB] randomized traffic with random backpressure");
        randomPhase(400);

        $display("[TB] FIFO backpressure");
        for (int k = 0; k < 12; k++) bd[k] = randData();
        base = outCnt3;
        out3.tready = 1'b0;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            in3.tvalid = (idx < 12);
            in3.tdata  = bd[(idx < 12) ? idx : 0];
            in3.tlast  = (idx == 11);
            @(negedge clk);
            if (in3.tvalid && in3.tready) idx++;
            @(posedge clk); #1;
        end
        checkOutput("bp_accepted", idx, 9);
        @(negedge clk);
        checkOutput("bp_ready", {63'd0, in3.tready}, 64'd0);
        if (in3.tvalid && in3.tready) idx++;
        @(posedge clk); #1;
        out3.tready = 1'b1;
        n = 0;
        while (idx < 12 && n < 50) begin
            in3.tvalid = 1'b1;
            in3.tdata  = bd[idx];
            in3.tlast  = (idx == 11);
            @(negedge clk);
            if (in3.tready) idx++;
            n++;
            @(posedge clk); #1;
        end
        in3.tvalid = 1'b0;
        n = 0;
        while (q3.size() != 0 && n < 50) begin @(posedge clk); n++; end
        #1;
        checkOutput("bp_emitted", outCnt3 - base, 12);

        $display("[TB] asynchronous reset with buffered beats");
        @(posedge clk); #1;
        out3.tready = 1'b0;
        for (int k = 0; k < 3; k++) applyStimulus(1, randData(), k == 2);
        @(negedge clk);
        checkOutput("rst_pre_valid", {63'd0, out3.tvalid}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_async_out", {out3.tvalid, out3.tlast, out3.tdata}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        out3.tready = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready", {63'd0, in3.tready}, 64'd1);
        @(posedge clk); #1;
        nd = randData();
        applyStimulus(1, nd, 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!out3.tvalid && n < 10);
        checkOutput("rst_first", {out3.tvalid, out3.tlast, out3.tdata}, {30'd0, 1'b1, model(nd, 1'b1)});

        $display("[TB] synchronous clear with buffered beats");
        @(posedge clk); #1;
        out3.tready = 1'b0;
        for (int k = 0; k < 3; k++) applyStimulus(1, randData(), 1'b0);
        clear = 1'b1;
        in3.tvalid = 1'b1;
        in3.tdata  = randData();
        in3.tlast  = 1'b0;
        @(negedge clk);
        checkOutput("clr_pre_valid", {63'd0, out3.tvalid}, 64'd1);
        @(posedge clk); #1;
        clear = 1'b0;
        in3.tvalid = 1'b0;
        @(negedge clk);
        checkOutput("clr_out", {out3.tvalid, out3.tlast, out3.tdata}, 64'd0);
        checkOutput("clr_ready", {63'd0, in3.tready}, 64'd1);
        @(posedge clk); #1;
        out3.tready = 1'b1;
        nd = randData();
        applyStimulus(1, nd, 1'b0);
        @(negedge clk);
        checkOutput("fifo_lat_c1", {63'd0, out3.tvalid}, 64'd0);
        @(negedge clk);
        checkOutput("fifo_lat_c2", {out3.tvalid, out3.tlast, out3.tdata}, {30'd0, 1'b1, model(nd, 1'b0)});
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule

// File: doc/axis_cplx_round_clip.md
Name: axis_cplx_round_clip

Overview:
- AXI-Stream block that converts wide complex samples (I in upper half, Q in lower half) to narrow complex samples.
- Each component is rounded (LSBs dropped) and then saturated (MSBs clipped).
- An optional output FIFO decouples it from downstream backpressure.
- Sits after complex multipliers (e.g. equalizer cmul output: 2x32-bit product -> 2x16-bit Q15 sample).

Parameters:
- WIDTH_IN, 32: bits per input component (signed).
- WIDTH_OUT, 16: bits per output component (signed).
- CLIP_BITS, 1: MSBs removed by saturation. Rounding drops DROP = WIDTH_IN-WIDTH_OUT-CLIP_BITS LSBs; DROP >= 1 required.
- FIFOSIZE, 0: log2 depth of output FIFO; 0 = no FIFO.

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush, same effect as reset.
- i_tdata  in  2*WIDTH_IN  {I,Q}, two's complement.
- i_tlast  in  1  packet end.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  2*WIDTH_OUT  {I,Q} rounded/clipped.
- o_tlast  out  1  passes i_tlast through unchanged.
- o_tvalid  out  1  output valid.
- o_tready  in  1  downstream ready.

Behaviour:
- Arithmetic, per component x, independent for I and Q:
  - Compute in WIDTH_IN+1 bits: r = (x + 2^(DROP-1)) >>> DROP (arithmetic shift; ties round toward +infinity).
  - Saturate r to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1]; rounding overflow is also saturated.
- Pipeline stage:
  - One register stage with standard flop handshake: i_tready = ~stage_valid | downstream_ready.
  - Stage loads on i_tvalid & i_tready; holds data/last while valid & ~downstream_ready.
- Latency: FIFOSIZE=0 -> 1 cycle input beat to o_tvalid. FIFOSIZE>0 -> 2 cycles into an empty FIFO.
- Throughput: 1 beat/cycle when o_tready=1; no bubbles.
- FIFO (FIFOSIZE>0):
  - Depth 2^FIFOSIZE, pointer wrap modulo depth, stores {last,data}.
  - Write accepted when not full; read when o_tvalid & o_tready.
  - Simultaneous read+write when full: read frees the slot but the write is refused that cycle (ready from registered full flag). Simultaneous read+write otherwise: count unchanged.
  - Empty: o_tvalid=0.
- Reset/clear:
  - o_tvalid=0, o_tdata=0, o_tlast=0, pointers/count=0; i_tready=1 from the next cycle.
  - Mid-packet reset or clear discards all held beats; no partial beat is emitted.
  - clear has priority over a same-cycle handshake.
- AXI rules:
  - o_tdata/o_tlast stable while o_tvalid & ~o_tready.
  - o_tvalid never depends combinationally on o_tready.
  - No beat is duplicated or lost.

Decomposition:
- Package axis_cplx_pkg holds:
  - DROP computation function.
  - Saturation bounds as functions of WIDTH_OUT.
  - Round/saturate function, reused for I and Q.
- One sub-module, axis_ring_fifo (WIDTH, SIZE):
  - Instantiated only when FIFOSIZE>0 via generate.
  - Same handshake and clear semantics.

Test Plan (WIDTH_IN=32, WIDTH_OUT=16, CLIP_BITS=1, DROP=15):
- Rounding, I then Q, one beat each:
  - I=0x00004000 -> 0x0001; I=0x00003FFF -> 0x0000; I=0xFFFFC000 -> 0x0000.
  - Q=0xFFFFBFFF -> 0xFFFF.
- Saturation:
  - I=0x3FFF8000 -> 0x7FFF; I=0x40000000 -> 0x7FFF.
  - I=0xC0000000 -> 0x8000; I=0xBFFF0000 -> 0x8000.
  - I=0x3FFFC000 (rounding overflow) -> 0x7FFF.
- Streaming, o_tready=1, FIFOSIZE=0, 8-beat packet with tlast on beat 8:
  - 8 contiguous outputs, each 1 cycle after its input.
  - tlast only on output 8.
- Backpressure, FIFOSIZE=3: o_tready=0 for 20 cycles while driving 12 beats:
  - 9 accepted (8 FIFO + 1 stage), then i_tready=0.
  - o_tdata stable throughout.
  - After release, all 12 beats emerge in order, no loss.
- Reset/clear:
  - reset_n=0 asynchronously mid-packet with 3 beats buffered -> o_tvalid=0 immediately.
  - After release, first output is the first new beat.
  - clear=1 for one cycle behaves identically.
